// File: rtl/sram_2rw_param.sv
// sram_2rw_param: parametrised true dual-port synchronous RAM, both ports on one clock.
// The array is swept to zero after every reset before requests are accepted.
// Byte write masks are supported. Port A wins bytes on a same-address write/write.
// Reads are read-first and return the old word when the other port writes it.
// Optional feature: define SRAM_OUT_REG_EN to add one output register stage per port.
// With it, read latency is 2 instead of 1.
module sram_2rw_param #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int MASK_W = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [MASK_W-1:0] a_wmask,
    input  logic [WIDTH-1:0]  a_wdata,
    output logic [WIDTH-1:0]  a_rdata,
    output logic              a_rvalid,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [MASK_W-1:0] b_wmask,
    input  logic [WIDTH-1:0]  b_wdata,
    output logic [WIDTH-1:0]  b_rdata,
    output logic              b_rvalid,
    output logic              collision
);
    localparam int BYTE_W = 32'sd8;

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic              init_done_r;
    logic [WIDTH-1:0]  mem_r [DEPTH];

    logic              a_wr_s, b_wr_s, a_rd_s, b_rd_s, same_addr_s;
    logic [WIDTH-1:0]  a_word_s, b_word_s;
    logic [WIDTH-1:0]  a_rdata1_r, b_rdata1_r;
    logic              a_rvalid1_r, b_rvalid1_r;
    logic              collision_r;

    // Addresses past the last word exist only when DEPTH is not a power of two.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return (int'(addr) < DEPTH);
    endfunction

    // Replace the bytes of old_word selected by mask with the matching bytes of new_word.
    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_word,
                                                     input logic [WIDTH-1:0] new_word,
                                                     input logic [MASK_W-1:0] mask);
        logic [WIDTH-1:0] res;
        res = old_word;
        for (int k = 32'sd0; k < MASK_W; k++) begin
            if (mask[k]) begin
                res[BYTE_W*k +: BYTE_W] = new_word[BYTE_W*k +: BYTE_W];
            end
        end
        return res;
    endfunction

    // Qualify this cycle's requests and build the merged words each port would store.
    always_comb begin
        a_wr_s      = init_done_r & a_en & a_we & (|a_wmask) & addr_ok(a_addr);
        b_wr_s      = init_done_r & b_en & b_we & (|b_wmask) & addr_ok(b_addr);
        a_rd_s      = init_done_r & a_en & ~a_we;
        b_rd_s      = init_done_r & b_en & ~b_we;
        same_addr_s = (a_addr == b_addr);
        b_word_s    = merge_bytes(mem_r[b_addr], b_wdata, b_wmask);
        // On a same-address double write, A's bytes are layered on top of B's merge.
        if (b_wr_s && same_addr_s) begin
            a_word_s = merge_bytes(b_word_s, a_wdata, a_wmask);
        end else begin
            a_word_s = merge_bytes(mem_r[a_addr], a_wdata, a_wmask);
        end
    end

    // Clear sequencer: sweep every word once after reset, then remain in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_INIT;
            cnt_r       <= {ADDR_W{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (cnt_r == ADDR_W'(DEPTH - 32'sd1)) begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + ADDR_W'(1'b1);
                    end
                end
                ST_RUN: begin
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_INIT;
                    cnt_r       <= {ADDR_W{1'b0}};
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Array update: zero fill while clearing, masked port writes in RUN (A issued last).
    always_ff @(posedge clk) begin
        if (rst) begin
            // Contents are left alone; the clear sweep that follows zeroes them.
        end else if (state_r == ST_INIT) begin
            mem_r[cnt_r] <= {WIDTH{1'b0}};
        end else begin
            if (b_wr_s) begin
                mem_r[b_addr] <= b_word_s;
            end
            if (a_wr_s) begin
                mem_r[a_addr] <= a_word_s;
            end
        end
    end

    // First read stage: capture old contents (read-first) and flag the new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata1_r  <= {WIDTH{1'b0}};
            b_rdata1_r  <= {WIDTH{1'b0}};
            a_rvalid1_r <= 1'b0;
            b_rvalid1_r <= 1'b0;
            collision_r <= 1'b0;
        end else begin
            a_rvalid1_r <= a_rd_s;
            b_rvalid1_r <= b_rd_s;
            collision_r <= a_wr_s & b_wr_s & same_addr_s;
            if (a_rd_s) begin
                a_rdata1_r <= addr_ok(a_addr) ? mem_r[a_addr] : {WIDTH{1'b0}};
            end
            if (b_rd_s) begin
                b_rdata1_r <= addr_ok(b_addr) ? mem_r[b_addr] : {WIDTH{1'b0}};
            end
        end
    end

`ifdef SRAM_OUT_REG_EN
    logic [WIDTH-1:0] a_rdata2_r, b_rdata2_r;
    logic             a_rvalid2_r, b_rvalid2_r;

    // Output stage: delay the strobe one cycle and hold data until the next read lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata2_r  <= {WIDTH{1'b0}};
            b_rdata2_r  <= {WIDTH{1'b0}};
            a_rvalid2_r <= 1'b0;
            b_rvalid2_r <= 1'b0;
        end else begin
            a_rvalid2_r <= a_rvalid1_r;
            b_rvalid2_r <= b_rvalid1_r;
            if (a_rvalid1_r) begin
                a_rdata2_r <= a_rdata1_r;
            end
            if (b_rvalid1_r) begin
                b_rdata2_r <= b_rdata1_r;
            end
        end
    end

    assign a_rdata  = a_rdata2_r;
    assign b_rdata  = b_rdata2_r;
    assign a_rvalid = a_rvalid2_r;
    assign b_rvalid = b_rvalid2_r;
`else
    assign a_rdata  = a_rdata1_r;
    assign b_rdata  = b_rdata1_r;
    assign a_rvalid = a_rvalid1_r;
    assign b_rvalid = b_rvalid1_r;
`endif

    assign init_done = init_done_r;
    assign collision = collision_r;

endmodule

// File: tb/tb_sram_2rw_param.sv
// tb_sram_2rw_param: directed bench for sram_2rw_param (16x16 default build).
// Expected read data and its due cycle are queued per port when a read is issued.
// A negedge monitor pops each entry and checks rvalid and rdata.
// In cycles where no read is due, the monitor requires rvalid to be low.
module tb_sram_2rw_param;
    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
`ifdef SRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic        a_en, a_we, b_en, b_we;
    logic [3:0]  a_addr, b_addr;
    logic [1:0]  a_wmask, b_wmask;
    logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic        a_rvalid, b_rvalid, collision;

    exp_t qa[$];
    exp_t qb[$];
    int   edge_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic mon_on = 1'b0;

    sram_2rw_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wmask(a_wmask),
        .a_wdata(a_wdata), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wmask(b_wmask),
        .b_wdata(b_wdata), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .collision(collision)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_en = 1'b0; a_we = 1'b0; a_addr = 4'd0; a_wmask = 2'b00; a_wdata = 16'h0000;
        b_en = 1'b0; b_we = 1'b0; b_addr = 4'd0; b_wmask = 2'b00; b_wdata = 16'h0000;
    endtask

    task automatic a_write(input logic [3:0] addr, input logic [15:0] d, input logic [1:0] m);
        a_en = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = d; a_wmask = m;
    endtask

    task automatic b_write(input logic [3:0] addr, input logic [15:0] d, input logic [1:0] m);
        b_en = 1'b1; b_we = 1'b1; b_addr = addr; b_wdata = d; b_wmask = m;
    endtask

    task automatic a_read(input logic [3:0] addr, input logic [15:0] exp);
        exp_t e;
        a_en = 1'b1; a_we = 1'b0; a_addr = addr; a_wmask = 2'b00;
        e.data = exp; e.due = edge_cnt + LAT;
        qa.push_back(e);
    endtask

    task automatic b_read(input logic [3:0] addr, input logic [15:0] exp);
        exp_t e;
        b_en = 1'b1; b_we = 1'b0; b_addr = addr; b_wmask = 2'b00;
        e.data = exp; e.due = edge_cnt + LAT;
        qb.push_back(e);
    endtask

    // Port A monitor: a due entry must arrive exactly on time, otherwise rvalid stays low.
    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (qa.size() > 0 && qa[0].due == edge_cnt) begin
                e = qa.pop_front();
                check_bit("a_rvalid_due", a_rvalid, 1'b1);
                check_word("a_rdata", a_rdata, e.data);
            end else begin
                check_bit("a_rvalid_idle", a_rvalid, 1'b0);
            end
        end
    end

    // Port B monitor: same rules as port A.
    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (qb.size() > 0 && qb[0].due == edge_cnt) begin
                e = qb.pop_front();
                check_bit("b_rvalid_due", b_rvalid, 1'b1);
                check_word("b_rdata", b_rdata, e.data);
            end else begin
                check_bit("b_rvalid_idle", b_rvalid, 1'b0);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        idle();
        rst = 1'b1;
        step();
        step();
        mon_on = 1'b1;
        check_bit("rst_init_done", init_done, 1'b0);
        check_bit("rst_a_rvalid", a_rvalid, 1'b0);
        check_bit("rst_b_rvalid", b_rvalid, 1'b0);
        check_bit("rst_collision", collision, 1'b0);
        check_word("rst_a_rdata", a_rdata, 16'h0000);
        check_word("rst_b_rdata", b_rdata, 16'h0000);

        // Clear sequence: init_done exactly DEPTH cycles after rst falls.
        rst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!init_done && n < 40);
        check_word("init_cycles", 16'(n), 16'd16);

        // Every word reads back as zero after the clear.
        for (int i = 0; i < DEPTH; i++) begin
            a_read(4'(i), 16'h0000);
            b_read(4'(DEPTH - 1 - i), 16'h0000);
            step();
        end
        idle();
        step();
        check_bit("sweep_no_collision", collision, 1'b0);
        step();

        // Masked write followed by a read on the other port.
        a_write(4'd3, 16'hBEEF, 2'b11); step();
        a_write(4'd3, 16'h1234, 2'b01); step();
        idle(); b_read(4'd3, 16'hBE34); step();
        idle(); step(); step();

        // Full-mask write/write collision: port A wins.
        a_write(4'd5, 16'hAAAA, 2'b11); b_write(4'd5, 16'h5555, 2'b11); step();
        check_bit("collision_full", collision, 1'b1);
        idle(); step();
        check_bit("collision_pulse_end", collision, 1'b0);
        a_read(4'd5, 16'hAAAA); step();
        idle(); step();

        // Split-mask collision: high byte from A, low byte from B.
        a_write(4'd5, 16'hAAAA, 2'b10); b_write(4'd5, 16'h5555, 2'b01); step();
        check_bit("collision_split", collision, 1'b1);
        idle(); step();
        a_read(4'd5, 16'hAA55); b_read(4'd5, 16'hAA55); step();
        check_bit("collision_read_read", collision, 1'b0);
        idle(); step();

        // Writes to different addresses never collide.
        a_write(4'd6, 16'h1111, 2'b11); b_write(4'd9, 16'h2222, 2'b11); step();
        check_bit("collision_diff_addr", collision, 1'b0);
        idle(); a_read(4'd6, 16'h1111); b_read(4'd9, 16'h2222); step();
        idle(); step(); step();

        // Read-first across ports.
        a_write(4'd7, 16'h0F0F, 2'b11); step();
        a_write(4'd7, 16'hFFFF, 2'b11); b_read(4'd7, 16'h0F0F); step();
        idle(); b_read(4'd7, 16'hFFFF); step();
        idle(); step(); step();

        // Writes leave previously read data on rdata.
        a_write(4'd7, 16'h3333, 2'b11); step();
        idle(); step();
        check_word("b_rdata_hold", b_rdata, 16'hFFFF);

        // A zero-mask write changes nothing.
        a_write(4'd3, 16'h0000, 2'b00); step();
        check_bit("mask0_no_collision", collision, 1'b0);
        idle(); a_read(4'd3, 16'hBE34); step();
        idle(); step(); step();

        // Reset in the same cycle as a read discards it.
        a_en = 1'b1; a_we = 1'b0; a_addr = 4'd2; rst = 1'b1;
        step();
        rst = 1'b0; idle();
        check_bit("rstread_rvalid", a_rvalid, 1'b0);
        check_word("rstread_rdata", a_rdata, 16'h0000);
        check_bit("rstread_init_done", init_done, 1'b0);
        step();
        check_bit("rstread_rvalid2", a_rvalid, 1'b0);
        check_word("rstread_rdata2", a_rdata, 16'h0000);

        // Reset in the middle of the clear, with cnt at 8, restarts it.
        for (int i = 0; i < 7; i++) step();
        check_bit("midclear_init_done", init_done, 1'b0);
        rst = 1'b1; step(); rst = 1'b0;
        n = 0;
        do begin
            if (n == 10) begin
                a_write(4'd0, 16'hFFFF, 2'b11);
                b_en = 1'b1; b_we = 1'b0; b_addr = 4'd0;
            end else begin
                idle();
            end
            step();
            n++;
        end while (!init_done && n < 40);
        check_word("midclear_cycles", 16'(n), 16'd16);
        idle(); a_read(4'd0, 16'h0000); b_read(4'd3, 16'h0000); step();
        idle(); a_read(4'd7, 16'h0000); step();
        idle();
        for (int i = 0; i < LAT + 2; i++) step();

        check_word("qa_drained", 16'(qa.size()), 16'd0);
        check_word("qb_drained", 16'(qb.size()), 16'd0);
        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_2rw_param.md
Name: sram_2rw_param

Overview:
- Parametrised true dual-port synchronous RAM: two independent read/write ports on one clock.
- Generalises the fixed 16x16 two-port SRAM model in width and depth, and adds byte write masks, read-valid strobes, defined same-address collision handling and a post-reset memory clear sequencer.
- Used as the storage primitive under lab FIFOs, register files and buffers.

Parameters:
- WIDTH, 16, data word width in bits; must be a multiple of 8.
- DEPTH, 16, number of words; must be at least 2.
- ADDR_W, $clog2(DEPTH), address width.
- MASK_W, WIDTH/8, byte-mask width.

Ports:
- clk  input  1  single clock for both ports.
- rst  input  1  synchronous reset, active-high.
- init_done  output  1  high once the memory clear has completed; requests are ignored while it is low.
- a_en  input  1  port A request valid.
- a_we  input  1  port A write (1) or read (0).
- a_addr  input  ADDR_W  port A address.
- a_wmask  input  MASK_W  port A byte write enables.
- a_wdata  input  WIDTH  port A write data.
- a_rdata  output  WIDTH  port A read data.
- a_rvalid  output  1  one-cycle pulse when a_rdata carries new read data.
- b_en, b_we, b_addr, b_wmask, b_wdata, b_rdata, b_rvalid: identical to the port A signals, for port B.
- collision  output  1  one-cycle pulse on a same-address write/write conflict.

Behaviour:
- Reset is synchronous and active-high on clk. It forces these values:
  - init_done=0, a_rvalid=0, b_rvalid=0, collision=0.
  - a_rdata=0, b_rdata=0.
  - clear counter=0.
- Reset does not change memory contents directly. Clearing is done by the INIT state.
- FSM states:
  - INIT: writes 0 to word[cnt] and increments cnt each cycle. When cnt==DEPTH-1, that word is written and the FSM moves to RUN. Clearing takes exactly DEPTH cycles after rst deasserts.
  - RUN: init_done=1; normal operation. The FSM stays in RUN until rst.
- rst asserted during INIT restarts the clear from address 0.
- rst asserted during RUN discards any in-flight read: rvalid is low in the next cycle.
- While init_done=0, a_en and b_en are ignored. No memory update and no rvalid result from them.
- Write (en=1, we=1): on the clock edge, byte k of word[addr] takes wdata[8k+7:8k] only where wmask[k]=1. Bytes with wmask=0 are unchanged.
- wmask=0 on a write is a no-op, with no other side effects.
- Read (en=1, we=0):
  - Latency 1: rdata and rvalid=1 are presented in the cycle after the request.
  - rvalid is high for exactly one cycle per read.
  - rdata holds its value until the next read on that port. Writes do not disturb rdata.
- Address beyond DEPTH-1 when DEPTH is not a power of 2:
  - A write has no effect.
  - A read returns 0 with rvalid=1.
- Read-during-write across ports at the same address in the same cycle: the reader gets the OLD data (read-first).
- Both ports writing the same address in the same cycle:
  - Port A wins on the bytes where both masks are set.
  - Bytes where only port B's mask is set take port B's data.
  - collision pulses 1 in the next cycle.
  - Different addresses, or both ports reading, never raise collision.
- Both ports reading the same address: both get identical data, with no collision.

Optional Feature:
- Macro: SRAM_OUT_REG_EN.
- Defined:
  - An extra output register stage is added per port, so read latency is 2. rvalid is delayed to match.
  - collision timing is unchanged (1 cycle).
  - Reset clears both stages.
  - Collision data semantics are unchanged.
- Undefined: read latency is 1, as described above.

Test Plan:
- Clear sequence: rst=1 for 2 cycles, then 0 -> init_done rises exactly DEPTH=16 cycles later. A read from every address then returns 0x0000 with rvalid=1.
- Masked write: port A writes addr 3, data 0xBEEF, mask 2'b11. Port A then writes addr 3, data 0x1234, mask 2'b01. Port B reads addr 3 -> b_rdata=0xBE34, b_rvalid for 1 cycle, latency 1 (2 with SRAM_OUT_REG_EN).
- Write/write collision: A writes addr 5, 0xAAAA, mask 2'b11 and B writes addr 5, 0x5555, mask 2'b11 in the same cycle -> collision=1 next cycle; a later read of addr 5 returns 0xAAAA. Repeat with A mask 2'b10 and B mask 2'b01 -> read returns 0xAA55.
- Read-first: word 7 holds 0x0F0F. A writes addr 7, 0xFFFF while B reads addr 7 in the same cycle -> b_rdata=0x0F0F; the next B read returns 0xFFFF.
- Reset mid-clear: pulse rst when cnt=8 -> init_done stays low for a further 16 cycles after rst deasserts. Requests issued during that time produce no rvalid and no memory change.
- Reset mid-read: A reads addr 2, and rst is asserted in the same cycle -> a_rvalid=0 and a_rdata=0 in the next cycle.
